code_lock_fsm: RTL and testbench
================================

Name: code_lock_fsm

Overview:
Parametrised sequential code-lock controller, successor to the fixed 4-step, 2-bit keypad lock FSM. It accepts a stream of DIGIT_W-bit key entries and compares each against a DIGITS-long stored code. It produces grant/deny pulses, counts consecutive failures and enforces a timed lockout after MAX_FAILS failures. It also aborts stale partial entries after an idle timeout. It sits between the debounced button/switch front end and the LED/indicator drivers.

Parameters:
DIGIT_W, 2, width of one key entry and one code digit
DIGITS, 4, number of digits per attempt (>=2)
MAX_FAILS, 3, consecutive failed attempts that trigger lockout (>=1)
LOCKOUT_CYCLES, 16, clock cycles locked_out stays high (>=1)
TIMEOUT_CYCLES, 64, idle cycles after which a partial attempt is aborted (>=1)
CNT_W, 8, width of the grant counter

Ports:
clock  in  1  single system clock, rising edge
clear  in  1  asynchronous active-high reset
entry_valid  in  1  key entry present this cycle
entry  in  DIGIT_W  key value
code  in  DIGITS*DIGIT_W  secret code; digit 0 = MSB slice
unlock  out  1  one-cycle pulse, correct code entered
error  out  1  one-cycle pulse, wrong code entered
locked_out  out  1  high while entries are ignored due to lockout
digit_idx  out  clog2(DIGITS)  index of next expected digit
fail_count  out  clog2(MAX_FAILS+1)  consecutive failures
grant_count  out  CNT_W  total successful attempts, wraps mod 2^CNT_W
state  out  2  ENTER=0, GRANT=1, DENY=2, LOCKOUT=3

Behaviour:
- Reset (clear=1, async): state=ENTER, digit_idx=0, fail_count=0, grant_count=0, unlock=error=locked_out=0, mismatch flag=0, timers=0. Reset mid-attempt discards the attempt.
- All outputs are registered (Moore). unlock=1 iff state=GRANT. error=1 iff state=DENY. locked_out=1 iff state=LOCKOUT.
- ENTER: an entry is accepted on each rising edge with entry_valid=1.
  - On the first digit (digit_idx=0), code is captured into an internal register. The whole attempt is compared against this copy; later code changes take effect next attempt.
  - Digit i is compared with captured code[(DIGITS-i)*DIGIT_W-1 -: DIGIT_W]. Any mismatch sets a sticky mismatch flag.
  - The remaining digits are still consumed. There is no early reject, so attempt length does not leak which digit was wrong.
  - On a non-final digit: digit_idx increments.
  - On the final digit (digit_idx=DIGITS-1): digit_idx returns to 0. Next state is GRANT if no mismatch, including the final digit; otherwise it is DENY. Latency from the final-digit edge to unlock/error is 1 cycle.
- GRANT (1 cycle): fail_count<=0, grant_count<=grant_count+1, then ENTER. entry_valid is ignored.
- DENY (1 cycle): fail_count<=fail_count+1. If the new value equals MAX_FAILS, go to LOCKOUT; otherwise go to ENTER. entry_valid is ignored.
- LOCKOUT: held for exactly LOCKOUT_CYCLES cycles. All entries are ignored. On exit, fail_count<=0, mismatch flag<=0 and next state is ENTER.
- Idle timeout:
  - Applies in ENTER with digit_idx!=0. The idle counter resets on every accepted entry.
  - After TIMEOUT_CYCLES consecutive cycles with no entry, digit_idx<=0 and the mismatch flag is cleared.
  - No unlock/error pulse; fail_count is unchanged.
  - If an entry arrives in the same cycle the timeout would fire, the entry wins.
- The mismatch flag clears whenever digit_idx returns to 0.
- grant_count wraps from 2^CNT_W-1 to 0.

Test Plan:
Defaults, code=8'b10_01_11_00. Enter 2,1,3,0 on consecutive cycles -> unlock=1 for exactly 1 cycle, 1 cycle after the 4th entry; grant_count=1; fail_count=0; error never high.
Enter 2,0,3,0 -> error pulse 1 cycle after the 4th entry (not after the 2nd); fail_count=1; digit_idx=0.
Three wrong attempts -> after the 3rd DENY, locked_out=1 for exactly 16 cycles. Entries during lockout leave digit_idx=0. Afterwards fail_count=0 and 2,1,3,0 unlocks.
Two wrong attempts then correct -> unlock, fail_count returns to 0. A following wrong attempt gives fail_count=1, no lockout.
Enter 2,1 then idle 64 cycles -> digit_idx=0, no pulses. Then 2,1,3,0 unlocks. Change code to 0 after the first digit of an attempt -> the attempt is still judged against 8'b10_01_11_00.
Assert clear mid-attempt (after 2 digits) and during LOCKOUT -> all outputs are immediately 0 and state=ENTER. Run 256 grants -> grant_count wraps to 0.

Source files
------------

// File: rtl/code_lock_fsm.sv
// -----------------------------------------------------------------------------
// code_lock_fsm
//
// This module is a sequential code-lock controller. It takes a stream of
// DIGIT_W-bit key entries and checks them against a DIGITS-long code. The code
// is captured on the first digit of each attempt.
//
// Once a full attempt has been entered, the controller issues a one-cycle
// grant or deny pulse. It counts consecutive failures, and after MAX_FAILS of
// them it locks out all entries for LOCKOUT_CYCLES cycles. A partial attempt
// that sees no entry for TIMEOUT_CYCLES cycles is silently discarded.
//
// Ports
//   clock        in   system clock, rising edge
//   clear        in   asynchronous active-high reset
//   entry_valid  in   key entry present this cycle
//   entry        in   key value (DIGIT_W)
//   code         in   secret code, digit 0 in the MSB slice (DIGITS*DIGIT_W)
//   unlock       out  one-cycle pulse: correct code entered
//   error        out  one-cycle pulse: wrong code entered
//   locked_out   out  high while entries are ignored due to lockout
//   digit_idx    out  index of the next expected digit
//   fail_count   out  consecutive failed attempts
//   grant_count  out  successful attempts, wraps mod 2^CNT_W
//   state        out  ENTER=0, GRANT=1, DENY=2, LOCKOUT=3
// -----------------------------------------------------------------------------
module code_lock_fsm #(
  parameter int DIGIT_W        = 2,
  parameter int DIGITS         = 4,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic                          clock,
  input  logic                          clear,
  input  logic                          entry_valid,
  input  logic [DIGIT_W-1:0]            entry,
  input  logic [DIGITS*DIGIT_W-1:0]     code,
  output logic                          unlock,
  output logic                          error,
  output logic                          locked_out,
  output logic [$clog2(DIGITS)-1:0]     digit_idx,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count,
  output logic [CNT_W-1:0]              grant_count,
  output logic [1:0]                    state
);

  localparam int CODE_W = DIGITS * DIGIT_W;
  localparam int IDX_W  = $clog2(DIGITS);
  localparam int FC_W   = $clog2(MAX_FAILS + 1);
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_ENTER   = 2'd0,
    S_GRANT   = 2'd1,
    S_DENY    = 2'd2,
    S_LOCKOUT = 2'd3
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [FC_W-1:0]     fail_q;
  logic [CNT_W-1:0]    grant_q;
  logic                mismatch_q;
  logic [CODE_W-1:0]   code_q;
  logic [LOCK_W-1:0]   lock_cnt_q;
  logic [IDLE_W-1:0]   idle_q;
  logic                unlock_q;
  logic                error_q;
  logic                locked_q;

  // The first digit is judged against the live code input, because the
  // captured copy is only written on that same edge.
  logic [CODE_W-1:0]   ref_code;
  logic [DIGIT_W-1:0]  exp_digit;
  logic                digit_bad;
  logic                last_digit;
  logic [FC_W-1:0]     fail_inc;

  assign ref_code   = (idx_q == '0) ? code : code_q;
  assign exp_digit  = ref_code[(DIGITS - 1 - int'(idx_q)) * DIGIT_W +: DIGIT_W];
  assign digit_bad  = (entry != exp_digit);
  assign last_digit = (idx_q == IDX_W'(DIGITS - 1));
  assign fail_inc   = fail_q + FC_W'(1);

  // NOTE: every register in this block, including the captured code copy, is
  // cleared by the async reset and assigned with <= so all state updates see
  // the pre-edge values of each other.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q    <= S_ENTER;
      idx_q      <= '0;
      fail_q     <= '0;
      grant_q    <= '0;
      mismatch_q <= 1'b0;
      code_q     <= '0;
      lock_cnt_q <= '0;
      idle_q     <= '0;
      unlock_q   <= 1'b0;
      error_q    <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      // Pulses last exactly one cycle unless re-asserted below.
      unlock_q <= 1'b0;
      error_q  <= 1'b0;
      case (state_q)
        S_ENTER: begin
          if (entry_valid) begin
            idle_q <= '0;
            if (idx_q == '0) code_q <= code;
            if (last_digit) begin
              idx_q      <= '0;
              mismatch_q <= 1'b0;
              if (mismatch_q || digit_bad) begin
                state_q <= S_DENY;
                error_q <= 1'b1;
              end else begin
                state_q  <= S_GRANT;
                unlock_q <= 1'b1;
              end
            end else begin
              // All digits are consumed even after a mismatch, so the
              // attempt length never reveals which digit was wrong.
              idx_q      <= idx_q + IDX_W'(1);
              mismatch_q <= mismatch_q | digit_bad;
            end
          end else if (idx_q != '0) begin
            // Abort a stale partial attempt. An entry arriving on the firing
            // cycle takes the branch above instead, so the entry wins.
            if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
              idx_q      <= '0;
              mismatch_q <= 1'b0;
              idle_q     <= '0;
            end else begin
              idle_q <= idle_q + IDLE_W'(1);
            end
          end
        end

        S_GRANT: begin
          fail_q  <= '0;
          grant_q <= grant_q + CNT_W'(1);
          state_q <= S_ENTER;
        end

        S_DENY: begin
          fail_q <= fail_inc;
          if (fail_inc == FC_W'(MAX_FAILS)) begin
            state_q    <= S_LOCKOUT;
            locked_q   <= 1'b1;
            lock_cnt_q <= '0;
          end else begin
            state_q <= S_ENTER;
          end
        end

        S_LOCKOUT: begin
          if (lock_cnt_q == LOCK_W'(LOCKOUT_CYCLES - 1)) begin
            state_q    <= S_ENTER;
            locked_q   <= 1'b0;
            fail_q     <= '0;
            mismatch_q <= 1'b0;
          end else begin
            lock_cnt_q <= lock_cnt_q + LOCK_W'(1);
          end
        end

        default: state_q <= S_ENTER;
      endcase
    end
  end

  assign unlock      = unlock_q;
  assign error       = error_q;
  assign locked_out  = locked_q;
  assign digit_idx   = idx_q;
  assign fail_count  = fail_q;
  assign grant_count = grant_q;
  assign state       = state_q;

endmodule

// File: tb/tb_code_lock_fsm.sv
// -----------------------------------------------------------------------------
// tb_code_lock_fsm
//
// Scoreboard bench for code_lock_fsm.
//
// For each attempt, the stimulus side works out the expected outcome. It
// compares the entered digits as a whole word against the code that was
// present on the first digit. It then queues the expected pulse, and a
// negedge monitor pops and checks that pulse whenever unlock or error rises.
//
// Failure count, grant count and lockout are tracked as plain integers that
// follow the lock's rules.
// -----------------------------------------------------------------------------
module tb_code_lock_fsm;

  localparam int DIGIT_W        = 2;
  localparam int DIGITS         = 4;
  localparam int MAX_FAILS      = 3;
  localparam int LOCKOUT_CYCLES = 16;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int CNT_W          = 8;
  localparam logic [7:0] CODE0  = 8'b10_01_11_00;

  logic       clock       = 1'b0;
  logic       clear       = 1'b1;
  logic       entry_valid = 1'b0;
  logic [1:0] entry       = 2'd0;
  logic [7:0] code        = CODE0;
  logic       unlock, error, locked_out;
  logic [1:0] digit_idx;
  logic [1:0] fail_count;
  logic [7:0] grant_count;
  logic [1:0] state;

  code_lock_fsm #(
    .DIGIT_W(DIGIT_W), .DIGITS(DIGITS), .MAX_FAILS(MAX_FAILS),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .clear(clear), .entry_valid(entry_valid), .entry(entry),
    .code(code), .unlock(unlock), .error(error), .locked_out(locked_out),
    .digit_idx(digit_idx), .fail_count(fail_count), .grant_count(grant_count),
    .state(state)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit     grant;
    int     fail_pre;
    int     gcnt_pre;
    longint cyc;
  } exp_t;

  exp_t   exp_q[$];
  int     n_cmp = 0;
  int     n_fail = 0;
  longint cyc = 0;
  int     fail_m = 0;
  int     gcnt_m = 0;
  bit     lock_pending = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  exp_t e;
  always @(negedge clock) begin
    if (!clear && (unlock === 1'b1 || error === 1'b1)) begin
      if (exp_q.size() == 0) begin
        check("spurious_pulse", {62'd0, unlock, error}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("unlock", unlock, e.grant);
        check("error", error, !e.grant);
        check("pulse_cycle", cyc, e.cyc);
        check("fail_at_pulse", fail_count, e.fail_pre);
        if (e.grant) check("grant_at_pulse", grant_count, e.gcnt_pre % 256);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    entry_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [1:0] d);
    entry_valid = 1'b1;
    entry       = d;
    step();
    entry_valid = 1'b0;
  endtask

  function automatic logic [7:0] wrong_of(input logic [7:0] c);
    logic [7:0] x;
    x = 8'($urandom_range(255, 1));
    return c ^ x;
  endfunction

  // One full attempt. The expected outcome is a whole-word compare against
  // the code present at the first digit.
  task automatic attempt(input logic [7:0] att, input int max_gap,
                         input bit change_code, input logic [7:0] new_code,
                         input bit poke);
    logic [7:0] captured;
    logic [1:0] d;
    captured = code;
    for (int i = 0; i < DIGITS; i++) begin
      if (i > 0 && max_gap > 0) idle($urandom_range(max_gap, 0));
      d = att[(DIGITS-1-i)*DIGIT_W +: DIGIT_W];
      if (i == DIGITS - 1)
        exp_q.push_back('{grant: (att == captured), fail_pre: fail_m,
                          gcnt_pre: gcnt_m, cyc: cyc + 1});
      send(d);
      if (i == 0 && change_code) code = new_code;
    end
    // Result cycle: entries here must be ignored.
    entry_valid = poke;
    entry       = 2'($urandom);
    step();
    entry_valid = 1'b0;
    if (att == captured) begin
      fail_m = 0;
      gcnt_m++;
    end else begin
      fail_m++;
      if (fail_m == MAX_FAILS) lock_pending = 1'b1;
    end
    check("idx_after_attempt", digit_idx, 0);
    check("fail_after_attempt", fail_count, fail_m);
    check("locked_after_attempt", locked_out, lock_pending);
  endtask

  task automatic lockout();
    int n = 0;
    while (locked_out === 1'b1 && n < LOCKOUT_CYCLES + 8) begin
      entry_valid = 1'($urandom);
      entry       = 2'($urandom);
      step();
      n++;
    end
    entry_valid = 1'b0;
    check("lockout_len", n, LOCKOUT_CYCLES);
    check("idx_after_lockout", digit_idx, 0);
    check("fail_after_lockout", fail_count, 0);
    fail_m       = 0;
    lock_pending = 1'b0;
  endtask

  task automatic attempt_full(input logic [7:0] att, input int max_gap,
                              input bit change_code, input logic [7:0] new_code,
                              input bit poke);
    attempt(att, max_gap, change_code, new_code, poke);
    if (lock_pending) lockout();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_unlock"}, unlock, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_locked"}, locked_out, 0);
    check({tag, "_idx"}, digit_idx, 0);
    check({tag, "_fail"}, fail_count, 0);
    check({tag, "_grants"}, grant_count, 0);
    check({tag, "_state"}, state, 0);
  endtask

  task automatic do_clear(input string tag);
    #2 clear = 1'b1;
    #1 check_all_zero(tag);
    @(negedge clock);
    clear = 1'b0;
    step();
    fail_m       = 0;
    gcnt_m       = 0;
    lock_pending = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    #12 check_all_zero("reset");
    @(negedge clock);
    clear = 1'b0;
    step();

    // Correct code, then the 2,0,3,0 wrong entry.
    attempt_full(CODE0, 0, 1'b0, 8'd0, 1'b0);
    check("grants_after_first", grant_count, 1);
    attempt_full(8'b10_00_11_00, 0, 1'b0, 8'd0, 1'b0);

    // Two more failures reach MAX_FAILS and lock out; afterwards it unlocks.
    attempt_full(wrong_of(CODE0), 0, 1'b0, 8'd0, 1'b1);
    attempt_full(wrong_of(CODE0), 0, 1'b0, 8'd0, 1'b1);
    attempt_full(CODE0, 0, 1'b0, 8'd0, 1'b0);

    // Two failures, a success clears the streak, then a single failure.
    attempt_full(wrong_of(CODE0), 1, 1'b0, 8'd0, 1'b0);
    attempt_full(wrong_of(CODE0), 1, 1'b0, 8'd0, 1'b0);
    attempt_full(CODE0, 1, 1'b0, 8'd0, 1'b0);
    attempt_full(wrong_of(CODE0), 1, 1'b0, 8'd0, 1'b0);
    check("no_lock_single_fail", locked_out, 0);

    // An entry on the cycle the timeout would fire wins.
    send(2'd2);
    send(2'd1);
    idle(TIMEOUT_CYCLES - 1);
    check("idx_before_timeout", digit_idx, 2);
    send(2'd3);
    exp_q.push_back('{grant: 1'b1, fail_pre: fail_m, gcnt_pre: gcnt_m, cyc: cyc + 1});
    send(2'd0);
    idle(1);
    fail_m = 0;
    gcnt_m++;

    // A stale partial attempt with a wrong first digit is aborted.
    send(2'd1);
    send(2'd1);
    idle(TIMEOUT_CYCLES);
    check("idx_after_timeout", digit_idx, 0);
    check("fail_after_timeout", fail_count, fail_m);
    attempt_full(CODE0, 0, 1'b0, 8'd0, 1'b0);

    // A code change mid-attempt takes effect only on the next attempt.
    attempt_full(CODE0, 0, 1'b1, 8'd0, 1'b0);
    attempt_full(8'd0, 0, 1'b0, 8'd0, 1'b0);
    code = CODE0;
    attempt_full(8'd0, 0, 1'b1, 8'd0, 1'b0);
    code = CODE0;

    // Clear mid-attempt, with a nonzero fail streak and grant count.
    attempt_full(wrong_of(CODE0), 0, 1'b0, 8'd0, 1'b0);
    send(2'd2);
    send(2'd1);
    do_clear("clr_mid");
    attempt_full(CODE0, 0, 1'b0, 8'd0, 1'b0);

    // Clear during lockout.
    while (!lock_pending) attempt(wrong_of(CODE0), 0, 1'b0, 8'd0, 1'b0);
    idle(3);
    check("locked_before_clear", locked_out, 1);
    do_clear("clr_lock");
    attempt_full(CODE0, 0, 1'b0, 8'd0, 1'b0);

    // Randomized attempts.
    for (int k = 0; k < 40; k++) begin
      code = 8'($urandom);
      attempt_full(($urandom_range(1, 0) == 1) ? code : 8'($urandom), 3,
                   1'($urandom_range(3, 0) == 0), 8'($urandom), 1'($urandom));
    end
    code = CODE0;

    // 256 grants wrap the counter back to 0.
    do_clear("clr_wrap");
    for (int k = 0; k < 256; k++) attempt_full(CODE0, 0, 1'b0, 8'd0, 1'b0);
    check("grant_wrap", grant_count, 0);

    idle(5);
    check("pending_pulses", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
